// File: rtl/toggle_event_serializer.sv
// Generic synchronous FIFO used as the event queue.
// Latency: an entry pushed at edge N is presented on pop_dat after edge N.
// Backpressure: push_rdy low when full, pop_vld low when empty; flush overrides push and pop.
module tes_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push_vld,
    output logic                       push_rdy,
    input  logic [WIDTH-1:0]           push_dat,
    output logic                       pop_vld,
    input  logic                       pop_rdy,
    output logic [WIDTH-1:0]           pop_dat,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign push_rdy = (count != CW'(DEPTH));
    assign pop_vld  = (count != '0);
    assign do_push  = push_vld && push_rdy && !flush;
    assign do_pop   = pop_rdy && pop_vld && !flush;
    assign pop_dat  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end
endmodule

// Turns toggle-bank level changes into {channel, level} events sent as UART-style frames.
// Latency: change before E0 -> pending at E0, queued at E1, start bit driven from E2.
// Backpressure: full FIFO stalls pushes; repeated changes on a pending channel coalesce and set overflow.
module toggle_event_serializer #(
    parameter int NCH     = 6,
    parameter int DEPTH   = 4,
    parameter int BIT_DIV = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NCH-1:0]             toggle_in,
    input  logic                       clear,
    output logic                       ser_out,
    output logic                       ser_busy,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count,
    output logic                       overflow
);
    localparam int IW   = $clog2(NCH);
    localparam int EW   = IW + 1;
    localparam int CNTW = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
    localparam int BIW  = $clog2(EW);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } tx_state_t;

    logic [NCH-1:0]  prev;
    logic [NCH-1:0]  pending;
    logic [NCH-1:0]  chg;
    logic [NCH-1:0]  lowest;
    logic [NCH-1:0]  take;
    logic [IW-1:0]   sel_idx;
    logic            sel_level;
    logic            push_rdy;
    logic            push_fire;
    logic            pop_vld;
    logic [EW-1:0]   pop_dat;

    tx_state_t       state;
    logic [CNTW-1:0] bit_cnt;
    logic [BIW-1:0]  bit_idx;
    logic [EW-1:0]   shift;
    logic            bit_end;

    assign chg    = toggle_in ^ prev;
    // Two's-complement trick isolates the lowest set pending bit.
    assign lowest = pending & (~pending + 1'b1);

    always_comb begin
        sel_idx = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (pending[i]) begin
                sel_idx = IW'(i);
            end
        end
    end

    assign sel_level = |(toggle_in & lowest);
    assign push_fire = (|pending) && push_rdy;
    assign take      = push_fire ? lowest : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev     <= '0;
            pending  <= '0;
            overflow <= 1'b0;
        end else if (clear) begin
            prev     <= toggle_in;
            pending  <= '0;
            overflow <= 1'b0;
        end else begin
            prev    <= toggle_in;
            pending <= (pending & ~take) | chg;
            // A channel taken this edge captured its current level, so nothing is lost there.
            if (|(chg & pending & ~take)) begin
                overflow <= 1'b1;
            end
        end
    end

    tes_fifo #(
        .WIDTH(EW),
        .DEPTH(DEPTH)
    ) u_evq (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (clear),
        .push_vld (|pending),
        .push_rdy (push_rdy),
        .push_dat ({sel_idx, sel_level}),
        .pop_vld  (pop_vld),
        .pop_rdy  (state == ST_IDLE),
        .pop_dat  (pop_dat),
        .count    (fifo_count)
    );

    assign bit_end = (bit_cnt == CNTW'(BIT_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            bit_cnt  <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            ser_out  <= 1'b1;
            ser_busy <= 1'b0;
        end else if (clear) begin
            state    <= ST_IDLE;
            bit_cnt  <= '0;
            bit_idx  <= '0;
            ser_out  <= 1'b1;
            ser_busy <= 1'b0;
        end else begin
            bit_cnt <= bit_end ? '0 : bit_cnt + 1'b1;
            case (state)
                ST_IDLE: begin
                    bit_cnt <= '0;
                    if (pop_vld) begin
                        shift    <= pop_dat;
                        state    <= ST_START;
                        ser_out  <= 1'b0;
                        ser_busy <= 1'b1;
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        state   <= ST_DATA;
                        bit_idx <= '0;
                        ser_out <= shift[0];
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        if (bit_idx == BIW'(EW - 1)) begin
                            state   <= ST_STOP;
                            ser_out <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            shift   <= shift >> 1;
                            ser_out <= shift[1];
                        end
                    end
                end
                ST_STOP: begin
                    if (bit_end) begin
                        state    <= ST_IDLE;
                        ser_busy <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
